// File: rtl/megarom_ram_arbiter.sv
// megarom_ram_arbiter
// Shares one cartridge RAM port between the MSX-bus megarom datapath (HOST)
// and a ROM-image loader (LD). HOST always owns the port combinationally with
// no added latency; LD runs fixed-length accesses only in idle gaps and is
// aborted (and retried by the loader) whenever HOST or refresh activity shows up.
//
// Loader handshake: LD_REQ is a level held with stable LD_ADDR/LD_WE/LD_DIN
// until LD_ACK; LD_ACK is a single-cycle pulse marking completion, and for
// reads LD_DOUT is valid from that pulse until the next one. A dropped LD_REQ
// or a host collision ends the attempt without LD_ACK.

module megarom_ram_arbiter #(
    parameter int ADDR_BIT_WIDTH = 24,
    parameter int LOAD_CYCLES    = 4,
    parameter int HOST_GUARD     = 2
) (
    input  logic                      CLK,
    input  logic                      RESET_n,
    // host (megarom datapath) side
    input  logic [ADDR_BIT_WIDTH-1:0] HOST_ADDR,
    input  logic                      HOST_OE_n,
    input  logic                      HOST_WE_n,
    input  logic [7:0]                HOST_DIN,
    output logic [7:0]                HOST_DOUT,
    input  logic                      HOST_RFSH_n,
    // loader side
    input  logic                      LD_REQ,
    input  logic                      LD_WE,
    input  logic [ADDR_BIT_WIDTH-1:0] LD_ADDR,
    input  logic [7:0]                LD_DIN,
    output logic                      LD_ACK,
    output logic [7:0]                LD_DOUT,
    output logic                      LD_BUSY,
    // physical RAM side
    output logic [ADDR_BIT_WIDTH-1:0] RAM_ADDR,
    output logic                      RAM_OE_n,
    output logic                      RAM_WE_n,
    output logic [7:0]                RAM_DIN,
    input  logic [7:0]                RAM_DOUT,
    output logic                      RAM_RFSH_n,
    // debug view of the arbiter FSM (0 = IDLE, 1 = LOAD, 2 = DONE)
    output logic [1:0]                DBG_STATE
);

    localparam int CW = (LOAD_CYCLES > 2) ? $clog2(LOAD_CYCLES) : 1;
    localparam int GW = (HOST_GUARD > 1) ? $clog2(HOST_GUARD + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(LOAD_CYCLES - 1);
    localparam logic [GW-1:0] GUARD_INIT = GW'(HOST_GUARD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [GW-1:0]   r_guard;
    logic            r_ack;
    logic            r_busy;
    logic [7:0]      r_ld_dout;
    logic            w_host_act;
    logic            w_guard_clear;

    assign w_host_act    = !HOST_OE_n | !HOST_WE_n | !HOST_RFSH_n;
    assign w_guard_clear = (r_guard == '0);

    assign HOST_DOUT  = RAM_DOUT;
    assign RAM_RFSH_n = HOST_RFSH_n;
    assign LD_ACK     = r_ack;
    assign LD_BUSY    = r_busy;
    assign LD_DOUT    = r_ld_dout;
    assign DBG_STATE  = r_state;

    // Guard window: reloads on any host/refresh activity, counts down to 0 while idle.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_guard <= GUARD_INIT;
        end else if (w_host_act) begin
            r_guard <= GUARD_INIT;
        end else if (!w_guard_clear) begin
            r_guard <= r_guard - 1'b1;
        end
    end

    // Loader access FSM with registered ack/busy/read-data outputs.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_ld_dout <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    r_cnt <= '0;
                    // Host wins a same-cycle tie: the guard and host_act terms keep us here.
                    if (LD_REQ && !w_host_act && w_guard_clear) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_ack <= 1'b0;
                    if (w_host_act || !LD_REQ) begin
                        // Host took the port (or loader withdrew): drop the attempt, no ack.
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_ack   <= 1'b1;
                        if (!LD_WE) begin
                            r_ld_dout <= RAM_DOUT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // Access already finished; ack pulse ends here regardless of host activity.
                    r_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // RAM port mux: host passes straight through, loader only while in LOAD.
    always_comb begin
        RAM_ADDR = '0;
        RAM_DIN  = 8'h00;
        RAM_OE_n = 1'b1;
        RAM_WE_n = 1'b1;
        if (w_host_act) begin
            RAM_ADDR = HOST_ADDR;
            RAM_DIN  = HOST_DIN;
            RAM_OE_n = HOST_OE_n;
            RAM_WE_n = HOST_WE_n;
        end else if (r_state == S_LOAD) begin
            RAM_ADDR = LD_ADDR;
            RAM_DIN  = LD_WE ? LD_DIN : 8'h00;
            RAM_OE_n = LD_WE;
            RAM_WE_n = !LD_WE;
        end
    end

endmodule
